// File: rtl/pulse_gen_pkg.sv
// Shared types and elaboration helpers for the pulse generator.
package pulse_gen_pkg;

  // Generator phases. IDLE means nothing in flight and nothing queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Larger of two elaboration-time integers.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the phase down-counter: it must hold the longer of the two phases.
  function automatic int phase_width(input int hi_cyc, input int lo_cyc);
    return $clog2(max2(hi_cyc, lo_cyc) + 1);
  endfunction

endpackage

// File: rtl/pulse_gen.sv
// pulse_gen: turns single-cycle trigger events into a clean level waveform.
// Each accepted trigger yields one HIGH_CYC-long high phase followed by a
// guaranteed LOW_CYC-long low gap. Triggers that arrive while a pulse is in
// flight are counted (never merged) and replayed back-to-back.
//
// Handshake: trig is a fire-and-forget request, one request per high cycle,
// sampled on every rising clk edge. There is no ready; a request that finds the
// pending counter full is dropped and flagged by a one-cycle overflow pulse.
// dbg_state mirrors the FSM register for checkers.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int HIGH_CYC   = 2,
  parameter int LOW_CYC    = 1,
  parameter int PEND_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            trig,
  output logic                            sig_out,
  output logic                            busy,
  output logic [$clog2(PEND_DEPTH+1)-1:0] pend_cnt,
  output logic                            overflow,
  output state_t                          dbg_state
);

  localparam int PH_W = phase_width(HIGH_CYC, LOW_CYC);
  localparam int PC_W = $clog2(PEND_DEPTH + 1);

  // Down-counter reload values: the phase ends when the counter reads zero.
  localparam logic [PH_W-1:0] PH_HIGH_LAST = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] PH_LOW_LAST  = PH_W'(LOW_CYC - 1);
  localparam logic [PC_W-1:0] PEND_FULL    = PC_W'(PEND_DEPTH);

  // Parameter sanity: zero-length phases or an empty queue make no sense.
  if (HIGH_CYC < 1 || LOW_CYC < 1 || PEND_DEPTH < 1) begin : g_param_check
    $fatal(1, "pulse_gen: HIGH_CYC, LOW_CYC and PEND_DEPTH must all be >= 1");
  end

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [PC_W-1:0]   r_pend;
  logic              r_sig;
  logic              r_busy;
  logic              r_ovf;

  state_t            w_state_nxt;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [PC_W-1:0]   w_pend_nxt;
  logic              w_ovf_nxt;
  logic              w_start;
  logic [PC_W:0]     w_req;

  // A start point is either idle or the final cycle of the low gap, so
  // back-to-back pulses repeat every HIGH_CYC+LOW_CYC cycles with no extra gap.
  always_comb begin
    w_start = (r_state == IDLE) || ((r_state == LOW) && (r_phase == '0));
    w_req   = {1'b0, r_pend} + {{PC_W{1'b0}}, trig};
  end

  // Next-state, phase counter and pending-queue bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = 1'b0;

    if (w_start) begin
      // The head of the queue (or the fresh trig) is consumed here. With a full
      // queue plus a simultaneous trig the net count is unchanged: no drop.
      if (w_req != '0) begin
        w_state_nxt = HIGH;
        w_phase_nxt = PH_HIGH_LAST;
        w_pend_nxt  = PC_W'(w_req - {{PC_W{1'b0}}, 1'b1});
      end else begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    end else begin
      case (r_state)
        HIGH: begin
          if (r_phase == '0) begin
            w_state_nxt = LOW;
            w_phase_nxt = PH_LOW_LAST;
          end else begin
            w_phase_nxt = r_phase - PH_W'(1);
          end
        end
        LOW: begin
          // The zero case is a start point and handled above.
          w_phase_nxt = r_phase - PH_W'(1);
        end
        default: begin
          w_state_nxt = IDLE;
          w_phase_nxt = '0;
        end
      endcase

      // Mid-pulse triggers are queued; a full queue drops them visibly.
      if (trig) begin
        if (r_pend < PEND_FULL) begin
          w_pend_nxt = r_pend + PC_W'(1);
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end
    end
  end

  // State register; outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_pend  <= '0;
      r_sig   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_pend  <= w_pend_nxt;
      r_sig   <= (w_state_nxt == HIGH);
      r_busy  <= (w_state_nxt != IDLE);
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign sig_out   = r_sig;
  assign busy      = r_busy;
  assign pend_cnt  = r_pend;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

  // Structural invariants of the output set.
  a_sig_implies_busy : assert property (@(posedge clk) disable iff (!rst_n)
    sig_out |-> busy);
  a_pend_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    pend_cnt <= PEND_FULL);
  a_ovf_only_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    overflow |-> (pend_cnt == PEND_FULL));

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: a timeline model of accepted pulses checked every cycle,
// directed scenarios with hand-computed values, and a rising-edge detector fed
// by sig_out for end-to-end event counting.
module tb_pulse_gen;
  import pulse_gen_pkg::*;

  localparam int HC   = 2;
  localparam int LC   = 1;
  localparam int PD   = 4;
  localparam int PC_W = $clog2(PD + 1);

  // ---------------- clock / reset ----------------
  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            trig  = 1'b0;
  logic            sig_out;
  logic            busy;
  logic [PC_W-1:0] pend_cnt;
  logic            overflow;
  state_t          dbg_state;

  always #5 clk = ~clk;

  pulse_gen #(
    .HIGH_CYC  (HC),
    .LOW_CYC   (LC),
    .PEND_DEPTH(PD)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .sig_out  (sig_out),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // n: edges since reset release; tfree: first edge at which a new pulse may
  // start; last: edge at which the most recent pulse started.
  typedef struct packed {
    int   n;
    int   pend;
    int   tfree;
    int   last;
    logic ovf;
  } model_t;

  localparam model_t M_RST = '{n: 0, pend: 0, tfree: 0, last: -1000, ovf: 1'b0};

  model_t m = M_RST;
  int     m_ovf_tot = 0;

  function automatic model_t model_step(input model_t s, input logic t);
    model_t r;
    int     req;
    r     = s;
    r.n   = s.n + 1;
    r.ovf = 1'b0;
    if (r.n >= s.tfree) begin
      req = s.pend + (t ? 1 : 0);
      if (req > 0) begin
        r.pend  = req - 1;
        r.last  = r.n;
        r.tfree = r.n + HC + LC;
      end
    end else if (t) begin
      if (s.pend < PD) r.pend = s.pend + 1;
      else             r.ovf  = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= model_step(m, trig);
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("sig_out",  int'(sig_out),  ((m.n >= m.last) && (m.n < m.last + HC)) ? 1 : 0);
      check("busy",     int'(busy),     (m.n < m.tfree) ? 1 : 0);
      check("pend_cnt", int'(pend_cnt), m.pend);
      check("overflow", int'(overflow), int'(m.ovf));
      if (m.ovf) m_ovf_tot++;
    end
  end

  // ---------------- downstream rising-edge detector ----------------
  logic d_prev  = 1'b0;
  int   det_cnt = 0;
  always @(posedge clk) begin
    d_prev <= sig_out;
    if (sig_out && !d_prev) det_cnt <= det_cnt + 1;
  end

  // ---------------- scoreboard of expected pulse start edges ----------------
  logic [31:0] exp_q[$];
  int          edge_no = 0;
  logic        s_prev  = 1'b0;
  logic        track   = 1'b0;

  // ---------------- driver tasks ----------------
  // Drive trig for edge edge_no+1, then return at the following negedge.
  task automatic step(input logic t);
    logic [31:0] e;
    trig = t;
    @(negedge clk);
    edge_no++;
    if (track && sig_out && !s_prev) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("start_edge", edge_no, int'(e));
      end else begin
        check("start_unexpected", edge_no, -1);
      end
    end
    s_prev = sig_out;
  endtask

  task automatic do_reset();
    trig  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
    s_prev  = 1'b0;
  endtask

  task automatic end_track();
    check("starts_left", exp_q.size(), 0);
    exp_q.delete();
    track = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int det0, ovf0, ntrig;
    logic t;

    // Reset state.
    do_reset();
    check("rst_sig",  int'(sig_out),  0);
    check("rst_busy", int'(busy),     0);
    check("rst_pend", int'(pend_cnt), 0);
    check("rst_ovf",  int'(overflow), 0);

    // Single trig at edge 1.
    track = 1'b1;
    exp_q = '{32'd1};
    for (int e = 1; e <= 6; e++) begin
      step(e == 1);
      if (e == 1) check("t1_sig_e1", int'(sig_out), 1);
      if (e == 2) check("t1_sig_e2", int'(sig_out), 1);
      if (e == 3) check("t1_sig_e3", int'(sig_out), 0);
      if (e == 3) check("t1_busy_e3", int'(busy), 1);
      if (e == 4) check("t1_busy_e4", int'(busy), 0);
      check("t1_pend", int'(pend_cnt), 0);
    end
    end_track();

    // trig held at edges 1-3.
    do_reset();
    det0  = det_cnt;
    track = 1'b1;
    exp_q = '{32'd1, 32'd4, 32'd7};
    for (int e = 1; e <= 12; e++) begin
      step(e <= 3);
      if (e == 2)  check("t2_pend_e2", int'(pend_cnt), 1);
      if (e == 3)  check("t2_pend_e3", int'(pend_cnt), 2);
      if (e == 4)  check("t2_pend_e4", int'(pend_cnt), 1);
      if (e == 7)  check("t2_pend_e7", int'(pend_cnt), 0);
      if (e == 9)  check("t2_busy_e9", int'(busy), 1);
      if (e == 10) check("t2_busy_e10", int'(busy), 0);
    end
    check("t2_edges", det_cnt - det0, 3);
    end_track();

    // trig held at edges 1-8: queue fills, one drop at edge 8.
    do_reset();
    det0  = det_cnt;
    track = 1'b1;
    exp_q = '{32'd1, 32'd4, 32'd7, 32'd10, 32'd13, 32'd16, 32'd19};
    for (int e = 1; e <= 24; e++) begin
      step(e <= 8);
      if (e == 6)  check("t3_pend_e6", int'(pend_cnt), 4);
      if (e == 7)  check("t3_pend_e7", int'(pend_cnt), 4);
      if (e == 7)  check("t3_ovf_e7", int'(overflow), 0);
      if (e == 8)  check("t3_ovf_e8", int'(overflow), 1);
      if (e == 8)  check("t3_pend_e8", int'(pend_cnt), 4);
      if (e == 9)  check("t3_ovf_e9", int'(overflow), 0);
      if (e == 19) check("t3_pend_e19", int'(pend_cnt), 0);
      if (e == 21) check("t3_busy_e21", int'(busy), 1);
      if (e == 22) check("t3_busy_e22", int'(busy), 0);
    end
    check("t3_edges", det_cnt - det0, 7);
    end_track();

    // trig present in the last LOW cycle is taken at edge 4's start point.
    do_reset();
    track = 1'b1;
    exp_q = '{32'd1, 32'd4};
    for (int e = 1; e <= 8; e++) begin
      step((e == 1) || (e == 4));
      if (e == 3) check("t4_sig_e3", int'(sig_out), 0);
      if (e == 4) check("t4_sig_e4", int'(sig_out), 1);
      check("t4_pend", int'(pend_cnt), 0);
    end
    end_track();

    // Asynchronous reset mid-HIGH with two requests queued.
    do_reset();
    for (int e = 1; e <= 4; e++) step(1'b1);
    check("t5_pre_sig",  int'(sig_out),  1);
    check("t5_pre_pend", int'(pend_cnt), 2);
    trig = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_sig",  int'(sig_out),  0);
    check("t5_async_busy", int'(busy),     0);
    check("t5_async_pend", int'(pend_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
    s_prev  = 1'b0;
    track   = 1'b1;
    exp_q   = '{32'd1};
    for (int e = 1; e <= 5; e++) begin
      step(e == 1);
      if (e == 1) check("t5_sig_e1", int'(sig_out), 1);
      if (e == 2) check("t5_sig_e2", int'(sig_out), 1);
      if (e == 3) check("t5_sig_e3", int'(sig_out), 0);
      if (e == 4) check("t5_busy_e4", int'(busy), 0);
    end
    end_track();

    // Random trig at 20% into the edge detector.
    do_reset();
    det0  = det_cnt;
    ovf0  = m_ovf_tot;
    ntrig = 0;
    for (int i = 0; i < 1000; i++) begin
      t = ($urandom_range(0, 99) < 20);
      if (t) ntrig++;
      step(t);
    end
    for (int i = 0; i < 100 && busy; i++) step(1'b0);
    check("rand_drain_idle", int'(busy), 0);
    step(1'b0);
    check("rand_edge_count", det_cnt - det0, ntrig - (m_ovf_tot - ovf0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the run never reaches its summary.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

endmodule
